uart_rx_ctrl: RTL and testbench

- Controller that sits between the 8N1 receiver (rx_uart) and a host/bus peripheral.
- Owns the receiver's baud divisor, configured by the host or by auto-baud measurement on a 0x55 character.
- Drains completed bytes from the receiver into an N-entry show-ahead FIFO and handles the receiver's rx_read handshake.
- Reports FIFO occupancy, overflow and auto-baud status to the host.

---
 rtl/uart_rx_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Host-side controller for an 8N1 receiver: owns the baud divisor (host write or
// auto-baud on 0x55), drains received bytes into a show-ahead FIFO, reports status.
module uart_rx_ctrl #(
  parameter int          DEPTH       = 16,
  parameter int          AW          = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd867,
  parameter logic [15:0] MIN_DIV     = 16'd15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_pin,
  input  logic          cfg_wr,
  input  logic [15:0]   cfg_div,
  input  logic          ab_start,
  output logic [15:0]   baud_div,
  output logic          uart_clr_n,
  input  logic          uart_rx_done,
  input  logic [7:0]    uart_rx_byte,
  output logic          uart_rx_read,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          ab_busy,
  output logic          ab_err
);

  typedef enum logic [2:0] {
    AB_IDLE, AB_WAIT_IDLE, AB_WAIT_FALL, AB_MEASURE, AB_SETTLE
  } ab_state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  ab_state_t     state_q, state_d;
  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic          read_q, read_d, read_dly_q, read_dly_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   baud_div_q, baud_div_d;
  logic          clr_n_q, clr_n_d;
  logic          ab_busy_q, ab_busy_d, ab_err_q, ab_err_d;
  logic [15:0]   meas_q, meas_d;
  logic [19:0]   settle_q, settle_d;

  logic [7:0]    mem [DEPTH];
  logic          line, capture, accept, push, pop, drop, full;
  logic [19:0]   bit_cycles, settle_target;

  assign line = rx_s2_q;
  // The receiver keeps rx_done high for a cycle after it sees rx_read, so a
  // capture is blocked while rx_read is high and for the cycle after it.
  assign capture = uart_rx_done && !read_q && !read_dly_q;
  assign accept  = capture && !ab_busy_q;
  assign full    = (count_q == FULL_CNT);
  assign pop     = rd_en && (count_q != '0);
  assign push    = accept && (!full || pop);
  assign drop    = accept && full && !pop;

  // One frame (10 bit times) of continuous idle before the receiver is released.
  assign bit_cycles    = {4'd0, baud_div_q} + 20'd1;
  assign settle_target = (bit_cycles << 3) + (bit_cycles << 1);

  always_comb begin
    rx_s1_d    = rx_pin;
    rx_s2_d    = rx_s1_q;
    read_d     = capture;
    read_dly_d = read_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    baud_div_d = baud_div_q;
    clr_n_d    = 1'b1;
    ab_busy_d  = ab_busy_q;
    ab_err_d   = ab_err_q;
    meas_d     = meas_q;
    settle_d   = settle_q;
    if (cfg_wr && !ab_busy_q && !ab_start) begin
      baud_div_d = cfg_div;
      clr_n_d    = 1'b0;
    end
    case (state_q)
      AB_IDLE: begin
        if (ab_start) begin
          ab_busy_d = 1'b1;
          ab_err_d  = 1'b0;
          state_d   = AB_WAIT_IDLE;
        end
      end
      AB_WAIT_IDLE: if (line) state_d = AB_WAIT_FALL;
      AB_WAIT_FALL: begin
        if (!line) begin
          meas_d  = 16'd1;
          state_d = AB_MEASURE;
        end
      end
      AB_MEASURE: begin
        if (line) begin
          if (meas_q - 16'd1 >= MIN_DIV) begin
            baud_div_d = meas_q - 16'd1;
            settle_d   = '0;
            state_d    = AB_SETTLE;
          end else begin
            ab_err_d  = 1'b1;
            ab_busy_d = 1'b0;
            state_d   = AB_IDLE;
          end
        end else if (meas_q == 16'hFFFF) begin
          ab_err_d  = 1'b1;
          ab_busy_d = 1'b0;
          state_d   = AB_IDLE;
        end else begin
          meas_d = meas_q + 16'd1;
        end
      end
      AB_SETTLE: begin
        if (!line) begin
          settle_d = '0;
        end else if (settle_q + 20'd1 == settle_target) begin
          clr_n_d   = 1'b0;
          ab_busy_d = 1'b0;
          state_d   = AB_IDLE;
        end else begin
          settle_d = settle_q + 20'd1;
        end
      end
      default: state_d = AB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= AB_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      read_q     <= 1'b0;
      read_dly_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      baud_div_q <= DEFAULT_DIV;
      clr_n_q    <= 1'b1;
      ab_busy_q  <= 1'b0;
      ab_err_q   <= 1'b0;
      meas_q     <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      read_q     <= read_d;
      read_dly_q <= read_dly_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      baud_div_q <= baud_div_d;
      clr_n_q    <= clr_n_d;
      ab_busy_q  <= ab_busy_d;
      ab_err_q   <= ab_err_d;
      meas_q     <= meas_d;
      settle_q   <= settle_d;
    end
  end

  // Storage is not reset; an empty FIFO presents zero on rd_data instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= uart_rx_byte;
  end

  assign rd_valid     = (count_q != '0);
  assign rd_data      = rd_valid ? mem[rd_ptr_q] : 8'h00;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign baud_div     = baud_div_q;
  assign uart_clr_n   = clr_n_q;
  assign uart_rx_read = read_q;
  assign ab_busy      = ab_busy_q;
  assign ab_err       = ab_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: table of receiver bytes against a FIFO scoreboard,
// plus hand-written auto-baud, host-config and reset sequences.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk, rst_n, rx_pin, cfg_wr, ab_start;
  logic [15:0]   cfg_div, baud_div;
  logic          uart_clr_n, uart_rx_done, uart_rx_read;
  logic [7:0]    uart_rx_byte, rd_data;
  logic          rd_en, rd_valid, overflow, ovf_clr, ab_busy, ab_err;
  logic [AW:0]   count;

  uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .DEFAULT_DIV(16'd867), .MIN_DIV(16'd15)) dut (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin), .cfg_wr(cfg_wr), .cfg_div(cfg_div),
    .ab_start(ab_start), .baud_div(baud_div), .uart_clr_n(uart_clr_n),
    .uart_rx_done(uart_rx_done), .uart_rx_byte(uart_rx_byte), .uart_rx_read(uart_rx_read),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .overflow(overflow), .ovf_clr(ovf_clr), .ab_busy(ab_busy), .ab_err(ab_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int read_pulses = 0;
  int clr_pulses = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    if (uart_rx_read) read_pulses <= read_pulses + 1;
    if (!uart_clr_n)  clr_pulses  <= clr_pulses + 1;
  end

  typedef struct {
    logic [7:0]  data;
    logic [AW:0] exp_count;
    logic        exp_ovf;
    logic        keep;
  } vec_t;
  vec_t tbl[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Receiver model: raise rx_done, hold it through the cycle rx_read is seen.
  task automatic deliver(input logic [7:0] b);
    logic seen;
    int   p0;
    p0 = read_pulses;
    seen = 1'b0;
    uart_rx_byte = b;
    uart_rx_done = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (uart_rx_read) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
    uart_rx_done = 1'b0;
    @(negedge clk);
    check("rx_ack_seen", 32'(seen), 32'd1);
    check("rx_read_pulses", read_pulses - p0, 1);
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    check({name, "_valid"}, 32'(rd_valid), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({name, "_data"}, 32'(rd_data), 32'(e));
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic strobe_ab_start();
    ab_start = 1'b1;
    @(negedge clk);
    ab_start = 1'b0;
  endtask

  task automatic short_low_pulse();
    repeat (5) @(negedge clk);
    rx_pin = 1'b0;
    repeat (10) @(negedge clk);
    rx_pin = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  int p0, c0, n;
  logic found;
  logic [9:0] frame;

  initial begin
    rst_n = 1'b0; rx_pin = 1'b1; cfg_wr = 1'b0; cfg_div = '0; ab_start = 1'b0;
    uart_rx_done = 1'b0; uart_rx_byte = '0; rd_en = 1'b0; ovf_clr = 1'b0;
    for (int i = 0; i < 19; i++) begin
      if (i == 0)      tbl[i] = '{8'hA5, (AW+1)'(1), 1'b0, 1'b1};
      else if (i == 1) tbl[i] = '{8'h3C, (AW+1)'(2), 1'b0, 1'b1};
      else tbl[i] = '{8'(8'h40 + i), (AW+1)'((i > 17) ? 16 : i - 1), (i == 18), (i != 18)};
    end

    repeat (3) @(negedge clk);
    check("rst_baud_div", 32'(baud_div), 32'd867);
    check("rst_clr_n", 32'(uart_clr_n), 32'd1);
    check("rst_rx_read", 32'(uart_rx_read), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_ab_busy", 32'(ab_busy), 32'd0);
    check("rst_ab_err", 32'(ab_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two bytes, read back, then 17 bytes into a 16-deep FIFO.
    for (int i = 0; i < 19; i++) begin
      if (i == 2) begin
        pop_check("pop_a5");
        pop_check("pop_3c");
        check("empty_after_pops", 32'(rd_valid), 32'd0);
      end
      deliver(tbl[i].data);
      if (tbl[i].keep) exp_q.push_back(tbl[i].data);
      check("tbl_count", 32'(count), 32'(tbl[i].exp_count));
      check("tbl_overflow", 32'(overflow), 32'(tbl[i].exp_ovf));
    end

    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO: capture and pop in the same cycle.
    p0 = read_pulses;
    check("fullpop_head", 32'(rd_data), 32'(exp_q[0]));
    void'(exp_q.pop_front());
    uart_rx_byte = 8'hEE;
    uart_rx_done = 1'b1;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    exp_q.push_back(8'hEE);
    @(negedge clk);
    uart_rx_done = 1'b0;
    @(negedge clk);
    check("fullpop_read_pulses", read_pulses - p0, 1);
    check("fullpop_count", 32'(count), 32'd16);
    check("fullpop_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) pop_check("drain");
    check("drain_count", 32'(count), 32'd0);
    check("drain_valid", 32'(rd_valid), 32'd0);

    // rx_done held for three cycles.
    p0 = read_pulses;
    uart_rx_byte = 8'h77;
    uart_rx_done = 1'b1;
    repeat (3) @(negedge clk);
    uart_rx_done = 1'b0;
    exp_q.push_back(8'h77);
    repeat (2) @(negedge clk);
    check("hold3_read_pulses", read_pulses - p0, 1);
    check("hold3_count", 32'(count), 32'd1);
    pop_check("hold3_pop");

    // Auto-baud on 0x55 at 432 clocks per bit.
    strobe_ab_start();
    check("ab_busy_set", 32'(ab_busy), 32'd1);
    repeat (5) @(negedge clk);
    c0 = clr_pulses;
    frame = {1'b1, 8'h55, 1'b0};
    n = 0;
    found = 1'b0;
    fork
      begin
        for (int b = 0; b < 9; b++) begin
          rx_pin = frame[b];
          repeat (432) @(negedge clk);
        end
        rx_pin = 1'b1;
        while (n < 5000 && !found) begin
          @(negedge clk);
          n++;
          if (!uart_clr_n) found = 1'b1;
        end
      end
      begin
        repeat (2000) @(negedge clk);
        deliver(8'h55);
      end
    join
    check("ab_clr_delay", n, 4322);
    check("ab_baud_div", 32'(baud_div), 32'd431);
    check("ab_busy_clear", 32'(ab_busy), 32'd0);
    @(negedge clk);
    check("ab_clr_one_cycle", 32'(uart_clr_n), 32'd1);
    check("ab_clr_pulses", clr_pulses - c0, 1);
    check("ab_fifo_empty", 32'(count), 32'd0);
    check("ab_err_clear", 32'(ab_err), 32'd0);

    // Too-short start bit.
    strobe_ab_start();
    short_low_pulse();
    check("abe_err", 32'(ab_err), 32'd1);
    check("abe_busy", 32'(ab_busy), 32'd0);
    check("abe_baud_kept", 32'(baud_div), 32'd431);

    // Host config ignored while busy, accepted when idle.
    c0 = clr_pulses;
    strobe_ab_start();
    check("cfg_busy", 32'(ab_busy), 32'd1);
    check("cfg_err_cleared", 32'(ab_err), 32'd0);
    cfg_div = 16'd100;
    cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    repeat (3) @(negedge clk);
    check("cfg_ignored_div", 32'(baud_div), 32'd431);
    check("cfg_ignored_clr", clr_pulses - c0, 0);
    short_low_pulse();
    check("cfg_idle_again", 32'(ab_busy), 32'd0);
    c0 = clr_pulses;
    cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    check("cfg_div_loaded", 32'(baud_div), 32'd100);
    check("cfg_clr_low", 32'(uart_clr_n), 32'd0);
    @(negedge clk);
    check("cfg_clr_high", 32'(uart_clr_n), 32'd1);
    check("cfg_clr_pulses", clr_pulses - c0, 1);

    // Asynchronous reset with data queued and auto-baud running.
    deliver(8'h11);
    deliver(8'h22);
    check("mid_count", 32'(count), 32'd2);
    strobe_ab_start();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_count", 32'(count), 32'd0);
    check("arst_valid", 32'(rd_valid), 32'd0);
    check("arst_baud", 32'(baud_div), 32'd867);
    check("arst_busy", 32'(ab_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
